// File: rtl/whack_pkg.sv
// Shared types and helpers for the whack-a-mole hit judge: mole count,
// score width, FSM state encoding and BCD score arithmetic.
package whack_pkg;

   localparam int NUM_MOLES    = 3;
   localparam int SCORE_DIGITS = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARMED  = 2'd1,
      LOCKED = 2'd2
   } judge_state_t;

   typedef logic [3:0] bcd_digit_t;

   typedef struct packed {
      bcd_digit_t tens;
      bcd_digit_t ones;
   } score_t;

   // Saturates at 99.
   function automatic score_t bcd_inc(input score_t s);
      score_t r;
      r = s;
      if (s.tens == 4'd9 && s.ones == 4'd9) begin
         r = s;
      end else if (s.ones == 4'd9) begin
         r.tens = s.tens + 4'd1;
         r.ones = 4'd0;
      end else begin
         r.ones = s.ones + 4'd1;
      end
      return r;
   endfunction

   // Floors at 00.
   function automatic score_t bcd_dec(input score_t s);
      score_t r;
      r = s;
      if (s.tens == 4'd0 && s.ones == 4'd0) begin
         r = s;
      end else if (s.ones == 4'd0) begin
         r.tens = s.tens - 4'd1;
         r.ones = 4'd9;
      end else begin
         r.ones = s.ones - 4'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/key_debouncer.sv
// One push button: 2-flop synchronizer, consecutive-sample debouncer and a
// one-cycle press pulse on the debounced 0->1 transition.
module key_debouncer #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clock,
   input  logic reset,
   input  logic key_n,
   output logic press
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] TC = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic          level;
   logic [CW-1:0] cnt;
   logic          sampled;

   assign sampled = ~sync2;

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         level <= 1'b0;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         sync1 <= key_n;
         sync2 <= sync1;
         press <= 1'b0;
         // cnt holds the number of disagreeing samples already seen.
         if (sampled == level) begin
            cnt <= '0;
         end else if (cnt == TC) begin
            level <= sampled;
            cnt   <= '0;
            press <= sampled;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/hit_judge.sv
// Whack-a-mole hit judge: debounces the mole keys, judges hit/miss against
// the lit moles and keeps a two-digit BCD score.
// Optional HIT_JUDGE_PENALTY_EN: each miss decrements the score (floor 00).
module hit_judge
   import whack_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      game,
   input  logic [NUM_MOLES-1:0]      key_n,
   input  logic [NUM_MOLES-1:0]      mole,
   output logic                      hit,
   output logic                      miss,
   output logic                      turnoff,
   output logic [4*SCORE_DIGITS-1:0] score_bcd
);

   // state  | meaning
   // IDLE   | game off, score cleared, presses ignored
   // ARMED  | waiting for a whack on a lit mole
   // LOCKED | mole was hit, turnoff held until display clears mole

   logic [NUM_MOLES-1:0] press;
   judge_state_t         state;
   judge_state_t         state_next;
   score_t               score;
   score_t               score_next;
   logic                 hit_next;
   logic                 miss_next;

   for (genvar i = 0; i < NUM_MOLES; i++) begin : g_key
      key_debouncer #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
         .clock (clock),
         .reset (reset),
         .key_n (key_n[i]),
         .press (press[i])
      );
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         score <= '0;
         hit   <= 1'b0;
         miss  <= 1'b0;
      end else begin
         state <= state_next;
         score <= score_next;
         hit   <= hit_next;
         miss  <= miss_next;
      end
   end

   always_comb begin
      state_next = state;
      score_next = score;
      hit_next   = 1'b0;
      miss_next  = 1'b0;
      if (!game) begin
         state_next = IDLE;
         score_next = '0;
      end else begin
         unique case (state)
            IDLE: begin
               state_next = ARMED;
            end
            ARMED: begin
               if (press != '0 && mole != '0) begin
                  if ($onehot(press) && (press & mole) != '0) begin
                     hit_next   = 1'b1;
                     score_next = bcd_inc(score);
                     state_next = LOCKED;
                  end else begin
                     miss_next = 1'b1;
`ifdef HIT_JUDGE_PENALTY_EN
                     score_next = bcd_dec(score);
`else
                     score_next = score;
`endif
                  end
               end
            end
            LOCKED: begin
               if (mole == '0) state_next = ARMED;
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   assign turnoff   = (state == LOCKED);
   assign score_bcd = score;

endmodule

// File: tb/tb_hit_judge.sv
// Randomized self-checking bench for hit_judge with DEBOUNCE_CYCLES=4,
// checked against an integer score / lock-flag reference model.
module tb_hit_judge;

   logic       clock = 1'b0;
   logic       reset;
   logic       game;
   logic [2:0] key_n;
   logic [2:0] mole;
   wire        hit;
   wire        miss;
   wire        turnoff;
   wire  [7:0] score_bcd;

   int total = 0;
   int bad   = 0;
   int sc    = 0;
   bit locked = 1'b0;

`ifdef HIT_JUDGE_PENALTY_EN
   localparam bit PENALTY = 1'b1;
`else
   localparam bit PENALTY = 1'b0;
`endif

   hit_judge #(.DEBOUNCE_CYCLES(4)) dut (
      .clock     (clock),
      .reset     (reset),
      .game      (game),
      .key_n     (key_n),
      .mole      (mole),
      .hit       (hit),
      .miss      (miss),
      .turnoff   (turnoff),
      .score_bcd (score_bcd)
   );

   always #5 clock = ~clock;

   function automatic logic [7:0] to_bcd(input int s);
      return 8'(((s / 10) * 16) + (s % 10));
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Press mask, observe 13 sampled cycles, release; model predicts outcome.
   task automatic do_whack(input logic [2:0] mask, input string name);
      int hits = 0, misses = 0, hit_at = -1, miss_at = -1, both = 0;
      bit exp_hit = 1'b0, exp_miss = 1'b0;
      int exp_sc;
      if (!locked && mole != 3'b000 && mask != 3'b000) begin
         if ($countones(mask) == 1 && (mask & mole) != 3'b000) exp_hit = 1'b1;
         else exp_miss = 1'b1;
      end
      exp_sc = sc;
      if (exp_hit) exp_sc = (sc < 99) ? sc + 1 : 99;
      if (exp_miss && PENALTY) exp_sc = (sc > 0) ? sc - 1 : 0;
      key_n = ~mask;
      for (int k = 0; k <= 12; k++) begin
         @(negedge clock);
         if (hit)  begin hits++;   hit_at  = k; end
         if (miss) begin misses++; miss_at = k; end
         if (hit && miss) both++;
      end
      @(posedge clock); #1;
      key_n = 3'b111;
      tick(8);
      sc = exp_sc;
      locked = locked | exp_hit;
      total++;
      if (hits != (exp_hit ? 1 : 0)) begin
         bad++; $display("FAIL %s hit_count: got %0d want %0d", name, hits, exp_hit ? 1 : 0);
      end
      total++;
      if (hit_at != (exp_hit ? 7 : -1)) begin
         bad++; $display("FAIL %s hit_cycle: got %0d want %0d", name, hit_at, exp_hit ? 7 : -1);
      end
      total++;
      if (misses != (exp_miss ? 1 : 0) || miss_at != (exp_miss ? 7 : -1)) begin
         bad++; $display("FAIL %s miss: got count %0d at %0d want count %0d", name, misses, miss_at, exp_miss ? 1 : 0);
      end
      total++;
      if (both != 0) begin
         bad++; $display("FAIL %s hit_and_miss: got %0d want 0", name, both);
      end
      total++;
      if (score_bcd !== to_bcd(sc)) begin
         bad++; $display("FAIL %s score: got %h want %h", name, score_bcd, to_bcd(sc));
      end
      total++;
      if (turnoff !== locked) begin
         bad++; $display("FAIL %s turnoff: got %b want %b", name, turnoff, locked);
      end
   endtask

   task automatic do_unlock();
      mole = 3'b000;
      @(negedge clock);
      total++;
      if (turnoff !== 1'b1) begin
         bad++; $display("FAIL unlock_before: turnoff got %b want 1", turnoff);
      end
      @(negedge clock);
      total++;
      if (turnoff !== 1'b0) begin
         bad++; $display("FAIL unlock_after: turnoff got %b want 0", turnoff);
      end
      locked = 1'b0;
      @(posedge clock); #1;
   endtask

   task automatic pick_lit(output logic [2:0] m, output logic [2:0] k);
      int i;
      m = 3'($urandom_range(1, 7));
      do i = $urandom_range(0, 2); while (!m[i]);
      k = 3'b001 << i;
   endtask

   task automatic hit_only(input string name);
      logic [2:0] m, k;
      pick_lit(m, k);
      mole = m;
      do_whack(k, name);
   endtask

   task automatic hit_once(input string name);
      hit_only(name);
      do_unlock();
   endtask

   task automatic miss_once(input string name);
      logic [2:0] m, k;
      m = 3'($urandom_range(1, 7));
      do k = 3'($urandom_range(1, 7));
      while ($countones(k) == 1 && (k & m) != 3'b000);
      mole = m;
      do_whack(k, name);
   endtask

   task automatic clear_game();
      game = 1'b0;
      tick(1);
      sc = 0;
      locked = 1'b0;
      game = 1'b1;
      tick(2);
   endtask

   task automatic quiet_window(input int n, input string name);
      int pulses = 0;
      for (int k = 0; k < n; k++) begin
         @(negedge clock);
         if (hit || miss) pulses++;
      end
      @(posedge clock); #1;
      total++;
      if (pulses != 0) begin
         bad++; $display("FAIL %s pulses: got %0d want 0", name, pulses);
      end
      total++;
      if (score_bcd !== to_bcd(sc)) begin
         bad++; $display("FAIL %s score: got %h want %h", name, score_bcd, to_bcd(sc));
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; game = 1'b0; key_n = 3'b111; mole = 3'b000;
      tick(3);
      total++;
      if ({hit, miss, turnoff} !== 3'b000) begin
         bad++; $display("FAIL reset_flags: got %b want 000", {hit, miss, turnoff});
      end
      total++;
      if (score_bcd !== 8'h00) begin
         bad++; $display("FAIL reset_score: got %h want 00", score_bcd);
      end
      reset = 1'b0;
      game = 1'b1;
      tick(2);
   endtask

   task automatic test_first_hit();
      mole = 3'b001;
      do_whack(3'b001, "first_hit");
      do_unlock();
   endtask

   task automatic test_miss();
      while (sc < 5) hit_once("miss_setup");
      mole = 3'b010;
      do_whack(3'b001, "miss_wrong");
      do_whack(3'b010, "armed_after_miss");
      do_unlock();
   endtask

   task automatic test_glitch_multi();
      mole = 3'b001;
      key_n = 3'b110;
      tick(3);
      key_n = 3'b111;
      quiet_window(15, "glitch");
      do_whack(3'b011, "two_keys");
   endtask

   task automatic test_locked();
      hit_only("lock_hit");
      for (int j = 0; j < 3; j++) do_whack(3'($urandom_range(1, 7)), "locked_press");
      do_unlock();
      mole = 3'b100;
      do_whack(3'b100, "rearmed_hit");
      do_unlock();
   endtask

   task automatic test_random();
      for (int j = 0; j < 30; j++) begin
         mole = 3'($urandom_range(0, 7));
         do_whack(3'($urandom_range(0, 7)), "random");
         if (locked) do_unlock();
      end
   endtask

   task automatic test_reset_mid();
      mole = 3'b001;
      key_n = 3'b110;
      tick(4);
      reset = 1'b1;
      key_n = 3'b111;
      tick(1);
      reset = 1'b0;
      sc = 0;
      quiet_window(14, "reset_mid");
      hit_only("reset_lock_hit");
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      sc = 0;
      locked = 1'b0;
      total++;
      if (turnoff !== 1'b0 || score_bcd !== 8'h00) begin
         bad++; $display("FAIL reset_locked: got turnoff %b score %h want 0 00", turnoff, score_bcd);
      end
      tick(2);
   endtask

   task automatic test_game_drop();
      clear_game();
      while (sc < 42) begin
         hit_only("drop_setup");
         if (sc < 42) do_unlock();
      end
      game = 1'b0;
      tick(1);
      sc = 0;
      locked = 1'b0;
      total++;
      if (score_bcd !== 8'h00 || turnoff !== 1'b0) begin
         bad++; $display("FAIL game_drop: got score %h turnoff %b want 00 0", score_bcd, turnoff);
      end
      mole = 3'b001;
      key_n = 3'b110;
      tick(10);
      game = 1'b1;
      quiet_window(15, "held_across_game");
      key_n = 3'b111;
      tick(8);
   endtask

   task automatic test_score_limits();
      clear_game();
      while (sc < 9) hit_once("limit_setup");
      hit_once("nine_to_ten");
      while (sc < 99) hit_once("limit_ramp");
      hit_once("saturate_99");
      clear_game();
      miss_once("floor_00");
   endtask

   initial begin
      test_reset();
      test_first_hit();
      test_miss();
      test_glitch_multi();
      test_locked();
      test_random();
      test_reset_mid();
      test_game_drop();
      test_score_limits();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
